// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   XLEN / ILEN        : address and instruction widths
//   INSTR_NOP          : canonical NOP (addi x0, x0, 0) shown when nothing is buffered
//   DEFAULT_RESET_PC   : default fetch start address
//   fetch_entry_t      : one buffered fetch, {pc, instr}
//   word_align()       : clears the byte-offset bits of an address
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used as the fetch instruction buffer.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   flush_i       : empties the FIFO at the next edge; wins over push/pop
//   push_i        : write push_data_i (accepted when not full, or when full and popping)
//   push_data_i   : entry to write
//   pop_i         : remove the head entry (ignored when empty)
//   head_o        : oldest entry, read straight from the storage registers
//   full_o        : DEPTH entries held
//   empty_o       : no entries held
//   count_o       : number of entries held
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO can still push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues word reads to instruction
// memory, buffers returned words in program order and hands {instr, instr_pc}
// to the decoder. A redirect reloads the PC and discards everything buffered
// or still in flight.
//   clk, rst                         : clock, synchronous active-high reset
//   imem_req_valid/ready/addr        : fetch request channel (addr word aligned)
//   imem_resp_valid/data             : in-order read data, no back-pressure
//   instr_valid/ready, instr/instr_pc: decoder channel (NOP / 0 when empty)
//   redirect_valid/redirect_pc       : branch/jump target, low bits ignored
// Handshakes: a transfer happens on a cycle where valid and ready are both 1
// at the rising edge; valid never depends on a transfer completing later.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   kill_q, kill_d;

    // Request tag queue: PC of every live (not killed) in-flight request.
    logic [XLEN-1:0] tag_q [FIFO_DEPTH];
    logic [PW-1:0]   tag_wr_q, tag_wr_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d;

    logic            req_fire;
    logic            resp_live;
    logic            credit_ok;
    logic [CW:0]     occupancy;

    fetch_entry_t    fifo_in, fifo_head;
    logic            fifo_push, fifo_pop;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Credit check counts the slot freed by a pop this cycle; without it a
    // two-entry buffer could only sustain two instructions every three cycles.
    assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_count} - (CW+1)'(fifo_pop);
    assign credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);

    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = rst ? word_align(RESET_PC) : pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = !rst && !redirect_valid && !fifo_empty;
    assign instr       = (rst || fifo_empty) ? INSTR_NOP : fifo_head.instr;
    assign instr_pc    = (rst || fifo_empty) ? '0 : fifo_head.pc;
    assign fifo_pop    = instr_valid && instr_ready;

    // Responses owed to requests issued before a redirect are the oldest ones
    // (memory is in order), so they are dropped while kill_q is non-zero.
    assign resp_live = imem_resp_valid && (kill_q == '0) && !redirect_valid;
    assign fifo_push = resp_live && (!fifo_full || fifo_pop);
    assign fifo_in   = {tag_q[tag_rd_q], imem_resp_data};

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        kill_d     = kill_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        if (redirect_valid) begin
            pc_d       = word_align(redirect_pc);
            inflight_d = inflight_q - CW'(imem_resp_valid);
            kill_d     = inflight_d;
            tag_wr_d   = '0;
            tag_rd_d   = '0;
        end else begin
            if (req_fire) begin
                pc_d     = pc_q + 32'd4;
                tag_wr_d = ptr_inc(tag_wr_q);
            end
            if (resp_live) begin
                tag_rd_d = ptr_inc(tag_rd_q);
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
            if (imem_resp_valid && (kill_q != '0)) begin
                kill_d = kill_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= word_align(RESET_PC);
            inflight_q <= '0;
            kill_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && req_fire) begin
            tag_q[tag_wr_q] <= pc_q;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    // ---------------- clock / DUT signals ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    // ---------------- bench state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          cyc   = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          last_due = 0;
    logic [31:0] exp_pc = RST_PC;   // next PC the decoder must see
    logic [31:0] last_pop_pc = '0;
    logic [31:0] last_req_addr = '0;
    logic [31:0] pend_addr_q[$];    // memory model: accepted, unanswered requests
    int          pend_due_q[$];

    logic        o_rv, o_iv;
    logic [31:0] o_addr, o_instr, o_ipc;

    // Contents of instruction memory: an arbitrary fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) ^ {a[15:0], a[31:16]} ^ 32'h0000_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at negedge, update model, drive memory response.
    task automatic cycle();
        int due;
        @(negedge clk);
        o_rv    = imem_req_valid;
        o_addr  = imem_req_addr;
        o_iv    = instr_valid;
        o_instr = instr;
        o_ipc   = instr_pc;
        if (rst) begin
            chk("rst_req_valid", 32'(o_rv), 32'd0);
            chk("rst_instr_valid", 32'(o_iv), 32'd0);
            chk("rst_req_addr", o_addr, RST_PC);
            chk("rst_instr", o_instr, INSTR_NOP);
            chk("rst_instr_pc", o_ipc, 32'd0);
        end else if (redirect_valid) begin
            chk("redir_req_valid", 32'(o_rv), 32'd0);
            chk("redir_instr_valid", 32'(o_iv), 32'd0);
        end else begin
            if (o_rv) chk("req_align", 32'(o_addr[1:0]), 32'd0);
            if (o_iv && instr_ready) begin
                chk("pop_pc", o_ipc, exp_pc);
                chk("pop_instr", o_instr, mem_word(exp_pc));
                last_pop_pc = o_ipc;
                n_pop++;
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (imem_resp_valid && pend_addr_q.size() > 0) begin
            void'(pend_addr_q.pop_front());
            void'(pend_due_q.pop_front());
        end
        if (rst) begin
            pend_addr_q.delete();
            pend_due_q.delete();
            exp_pc = RST_PC;
        end else begin
            if (o_rv && imem_req_ready) begin
                due = cyc + $urandom_range(lat_lo, lat_hi);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_addr_q.push_back(o_addr);
                pend_due_q.push_back(due);
                last_req_addr = o_addr;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            chk("outstanding_le_depth", 32'(pend_addr_q.size() <= DEPTH), 32'd1);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (pend_addr_q.size() > 0 && pend_due_q[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_addr_q[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    task automatic wait_pop(input string tag, input int budget);
        int n0;
        int k;
        n0 = n_pop;
        k  = 0;
        while (n_pop == n0 && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, 32'(n_pop != n0), 32'd1);
    endtask

    initial begin
        int k;
        int held;
        int pop0;

        // ---- 1: reset, 1-cycle memory, back-to-back fetch ----
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        chk("t1_req_valid_after_rst", 32'(o_rv), 32'd1);
        chk("t1_iv_cycle1", 32'(o_iv), 32'd0);
        cycle();
        chk("t1_iv_cycle2", 32'(o_iv), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t1_iv_stream", 32'(o_iv), 32'd1);
            chk("t1_pc_stream", o_ipc, 32'(i * 4));
        end

        // ---- 2: decoder stall, requests throttle, order resumes ----
        instr_ready = 1'b0;
        repeat (10) cycle();
        chk("t2_req_valid_dropped", 32'(o_rv), 32'd0);
        chk("t2_instr_held", 32'(o_iv), 32'd1);
        chk("t2_held_pc", o_ipc, exp_pc);
        instr_ready = 1'b1;
        pop0 = n_pop;
        repeat (6) cycle();
        chk("t2_resumed", 32'(n_pop - pop0 >= 4), 32'd1);

        // ---- 3: redirect with two requests in flight ----
        lat_lo = 3;
        lat_hi = 3;
        k = 0;
        while (pend_addr_q.size() < 2 && k < 20) begin
            cycle();
            k++;
        end
        chk("t3_two_inflight", 32'(pend_addr_q.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0;
        wait_pop("t3_pop_timeout", 30);
        chk("t3_first_pc", last_pop_pc, 32'h0000_0100);

        // ---- 4: redirect together with a response, unaligned target ----
        lat_lo = 1;
        lat_hi = 1;
        repeat (6) cycle();
        k = 0;
        while (!imem_resp_valid && k < 10) begin
            cycle();
            k++;
        end
        chk("t4_resp_pending", 32'(imem_resp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("t4_req_valid", 32'(o_rv), 32'd1);
        chk("t4_req_addr", o_addr, 32'h0000_0200);
        wait_pop("t4_pop_timeout", 10);
        chk("t4_first_pc", last_pop_pc, 32'h0000_0200);

        // ---- 4b: PC wraps past the top of the address space ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        cycle();
        redirect_valid = 1'b0;
        wait_pop("t4b_pop1", 10);
        chk("t4b_pc1", last_pop_pc, 32'hFFFF_FFF8);
        wait_pop("t4b_pop2", 10);
        wait_pop("t4b_pop3", 10);
        chk("t4b_wrap_pc", last_pop_pc, 32'h0000_0000);

        // ---- 5: memory not ready, address held ----
        imem_req_ready = 1'b0;
        repeat (6) cycle();
        held = int'(o_addr);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_req_valid_held", 32'(o_rv), 32'd1);
            chk("t5_addr_stable", o_addr, 32'(held));
        end
        imem_req_ready = 1'b1;
        cycle();
        chk("t5_hs_addr", last_req_addr, 32'(held));
        cycle();
        chk("t5_next_addr", o_addr, 32'(held) + 32'd4);
        repeat (4) cycle();

        // ---- 6: reset with buffered and in-flight fetches ----
        lat_lo = 3;
        lat_hi = 3;
        instr_ready = 1'b0;
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        lat_lo = 1;
        lat_hi = 1;
        instr_ready = 1'b1;
        cycle();
        chk("t6_iv", 32'(o_iv), 32'd0);
        chk("t6_instr", o_instr, INSTR_NOP);
        chk("t6_instr_pc", o_ipc, 32'd0);
        chk("t6_req_valid", 32'(o_rv), 32'd1);
        chk("t6_req_addr", o_addr, RST_PC);
        wait_pop("t6_pop_timeout", 10);
        chk("t6_first_pc", last_pop_pc, RST_PC);

        // ---- random traffic against the program-order model ----
        lat_lo = 1;
        lat_hi = 3;
        pop0 = n_pop;
        for (int i = 0; i < 3000; i++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = $urandom();
            rst            = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        repeat (20) cycle();
        chk("rand_progress", 32'(n_pop - pop0 > 300), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
